// File: rtl/bydin_rs_arb.sv
// bydin_rs_arb: shares one RS decoder among NCH byte-deinterleaver channels.
// Grants one RS row at a time round-robin and latches that row's RS mode.
// Forwards the owner's bytes to the decoder and routes decoder output back.
// The grant is released on row finish or on watchdog expiry.
module bydin_rs_arb #(
  parameter int unsigned   NCH     = 4,
  parameter int unsigned   DW      = 8,
  parameter int unsigned   ROW_LEN = 240,
  parameter int unsigned   TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(4095)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NCH-1:0]                    ch_req,
  input  logic [2*NCH-1:0]                  ch_rs_mode,
  input  logic [NCH-1:0]                    ch_en_in,
  input  logic [DW*NCH-1:0]                 ch_din,
  output logic [NCH-1:0]                    ch_grant,
  output logic [NCH-1:0]                    ch_rs_en_out,
  output logic [DW-1:0]                     ch_rs_dout,
  output logic [NCH-1:0]                    ch_row_done,
  output logic [NCH-1:0]                    ch_timeout,
  output logic [1:0]                        rs_mode,
  output logic                              rs_en_in,
  output logic [DW-1:0]                     rs_din,
  input  logic                              rs_row_finish,
  input  logic                              rs_en_out,
  input  logic [DW-1:0]                     rs_dout,
  output logic                              busy,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] grant_id
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = $clog2(ROW_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_owner_q, last_owner_d;
  logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic [NCH-1:0]    ch_grant_q, ch_grant_d;
  logic [NCH-1:0]    ch_rs_en_out_q, ch_rs_en_out_d;
  logic [DW-1:0]     ch_rs_dout_q, ch_rs_dout_d;
  logic [NCH-1:0]    ch_row_done_q, ch_row_done_d;
  logic [NCH-1:0]    ch_timeout_q, ch_timeout_d;
  logic [1:0]        rs_mode_q, rs_mode_d;
  logic              rs_en_in_q, rs_en_in_d;
  logic [DW-1:0]     rs_din_q, rs_din_d;
  logic              busy_q, busy_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;

  logic              win_found;
  logic [IW-1:0]     win_id;
  logic [1:0]        win_mode;
  logic              own_en;
  logic [DW-1:0]     own_din;
  logic [TO_W-1:0]   wd_inc;
  logic [CW-1:0]     byte_inc;

  // Round-robin pick: first requester above last_owner, else lowest requester (wrap).
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!win_found && ch_req[i] && (IW'(i) > last_owner_q)) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!win_found && ch_req[i]) begin
        win_found = 1'b1;
        win_id    = IW'(i);
      end
    end
    win_mode = 2'b00;
    for (int i = 0; i < NCH; i++) begin
      if (IW'(i) == win_id) win_mode = ch_rs_mode[2*i +: 2];
    end
  end

  // Select the current owner's byte strobe and data.
  always_comb begin
    own_en  = 1'b0;
    own_din = '0;
    for (int i = 0; i < NCH; i++) begin
      if (IW'(i) == grant_id_q) begin
        own_en  = ch_en_in[i];
        own_din = ch_din[DW*i +: DW];
      end
    end
  end

  assign wd_inc   = wd_cnt_q + TO_W'(1);
  assign byte_inc = (byte_cnt_q == CW'(ROW_LEN)) ? byte_cnt_q : byte_cnt_q + CW'(1);

  // Next-state and output decode; pulses default low, everything else holds.
  always_comb begin
    state_d        = state_q;
    last_owner_d   = last_owner_q;
    byte_cnt_d     = byte_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    ch_grant_d     = ch_grant_q;
    ch_rs_en_out_d = '0;
    ch_rs_dout_d   = ch_rs_dout_q;
    ch_row_done_d  = '0;
    ch_timeout_d   = '0;
    rs_mode_d      = rs_mode_q;
    rs_en_in_d     = 1'b0;
    rs_din_d       = rs_din_q;
    busy_d         = busy_q;
    grant_id_d     = grant_id_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          for (int i = 0; i < NCH; i++) ch_grant_d[i] = (IW'(i) == win_id);
          grant_id_d = win_id;
          rs_mode_d  = win_mode;
          byte_cnt_d = '0;
          wd_cnt_d   = '0;
          busy_d     = 1'b1;
          state_d    = S_FEED;
        end
      end

      S_FEED, S_DRAIN: begin
        if (rs_en_out) begin
          ch_rs_en_out_d = ch_grant_q;
          ch_rs_dout_d   = rs_dout;
        end
        wd_cnt_d = wd_inc;
        if (rs_row_finish) begin
          ch_row_done_d = ch_grant_q;
          ch_grant_d    = '0;
          busy_d        = 1'b0;
          last_owner_d  = grant_id_q;
          state_d       = S_IDLE;
        end else if (wd_inc == TIMEOUT) begin
          ch_timeout_d  = ch_grant_q;
          ch_grant_d    = '0;
          busy_d        = 1'b0;
          last_owner_d  = grant_id_q;
          state_d       = S_IDLE;
        end else if ((state_q == S_FEED) && own_en) begin
          rs_en_in_d = 1'b1;
          rs_din_d   = own_din;
          byte_cnt_d = byte_inc;
          if (byte_inc == CW'(ROW_LEN)) state_d = S_DRAIN;
        end
      end

      default: begin
        ch_grant_d = '0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_owner_q   <= IW'(NCH - 1);
      byte_cnt_q     <= '0;
      wd_cnt_q       <= '0;
      ch_grant_q     <= '0;
      ch_rs_en_out_q <= '0;
      ch_rs_dout_q   <= '0;
      ch_row_done_q  <= '0;
      ch_timeout_q   <= '0;
      rs_mode_q      <= 2'b00;
      rs_en_in_q     <= 1'b0;
      rs_din_q       <= '0;
      busy_q         <= 1'b0;
      grant_id_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      byte_cnt_q     <= byte_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      ch_grant_q     <= ch_grant_d;
      ch_rs_en_out_q <= ch_rs_en_out_d;
      ch_rs_dout_q   <= ch_rs_dout_d;
      ch_row_done_q  <= ch_row_done_d;
      ch_timeout_q   <= ch_timeout_d;
      rs_mode_q      <= rs_mode_d;
      rs_en_in_q     <= rs_en_in_d;
      rs_din_q       <= rs_din_d;
      busy_q         <= busy_d;
      grant_id_q     <= grant_id_d;
    end
  end

  assign ch_grant     = ch_grant_q;
  assign ch_rs_en_out = ch_rs_en_out_q;
  assign ch_rs_dout   = ch_rs_dout_q;
  assign ch_row_done  = ch_row_done_q;
  assign ch_timeout   = ch_timeout_q;
  assign rs_mode      = rs_mode_q;
  assign rs_en_in     = rs_en_in_q;
  assign rs_din       = rs_din_q;
  assign busy         = busy_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_bydin_rs_arb.sv
// Directed bench for bydin_rs_arb: one instance with the default watchdog and
// one with a 16-cycle watchdog, both driven from the same stimulus.
module tb_bydin_rs_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  ch_req;
  logic [7:0]  ch_rs_mode;
  logic [3:0]  ch_en_in;
  logic [31:0] ch_din;
  logic        rs_row_finish;
  logic        rs_en_out;
  logic [7:0]  rs_dout;

  logic [3:0]  ch_grant, ch_rs_en_out, ch_row_done, ch_timeout;
  logic [7:0]  ch_rs_dout, rs_din;
  logic [1:0]  rs_mode, grant_id;
  logic        rs_en_in, busy;

  logic [3:0]  t_ch_grant, t_ch_rs_en_out, t_ch_row_done, t_ch_timeout;
  logic [7:0]  t_ch_rs_dout, t_rs_din;
  logic [1:0]  t_rs_mode, t_grant_id;
  logic        t_rs_en_in, t_busy;

  int n_tot = 0;
  int n_bad = 0;

  bydin_rs_arb #(.NCH(4), .DW(8), .ROW_LEN(240), .TO_W(16), .TIMEOUT(16'd4095)) dut (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_rs_mode(ch_rs_mode),
    .ch_en_in(ch_en_in), .ch_din(ch_din), .ch_grant(ch_grant),
    .ch_rs_en_out(ch_rs_en_out), .ch_rs_dout(ch_rs_dout), .ch_row_done(ch_row_done),
    .ch_timeout(ch_timeout), .rs_mode(rs_mode), .rs_en_in(rs_en_in), .rs_din(rs_din),
    .rs_row_finish(rs_row_finish), .rs_en_out(rs_en_out), .rs_dout(rs_dout),
    .busy(busy), .grant_id(grant_id)
  );

  bydin_rs_arb #(.NCH(4), .DW(8), .ROW_LEN(240), .TO_W(16), .TIMEOUT(16'd16)) dut_to (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_rs_mode(ch_rs_mode),
    .ch_en_in(ch_en_in), .ch_din(ch_din), .ch_grant(t_ch_grant),
    .ch_rs_en_out(t_ch_rs_en_out), .ch_rs_dout(t_ch_rs_dout), .ch_row_done(t_ch_row_done),
    .ch_timeout(t_ch_timeout), .rs_mode(t_rs_mode), .rs_en_in(t_rs_en_in), .rs_din(t_rs_din),
    .rs_row_finish(rs_row_finish), .rs_en_out(rs_en_out), .rs_dout(rs_dout),
    .busy(t_busy), .grant_id(t_grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    reset_n       = 1'b0;
    ch_req        = 4'b0000;
    ch_rs_mode    = 8'b11_10_01_10;
    ch_en_in      = 4'b0000;
    ch_din        = 32'h0;
    rs_row_finish = 1'b0;
    rs_en_out     = 1'b0;
    rs_dout       = 8'h00;
    tick();
    tick();

    chk("rst_grant",    32'(ch_grant), 32'h0);
    chk("rst_busy",     32'(busy), 32'h0);
    chk("rst_gid",      32'(grant_id), 32'h0);
    chk("rst_rs_en_in", 32'(rs_en_in), 32'h0);
    chk("rst_rs_mode",  32'(rs_mode), 32'h0);
    chk("rst_dout",     32'(ch_rs_dout), 32'h0);
    reset_n = 1'b1;
    tick();

    // First grant goes to channel 0 with its mode latched.
    ch_req = 4'b0001;
    tick();
    chk("g0_grant", 32'(ch_grant), 32'h1);
    chk("g0_busy",  32'(busy), 32'h1);
    chk("g0_gid",   32'(grant_id), 32'h0);
    chk("g0_mode",  32'(rs_mode), 32'h2);
    ch_req = 4'b0000;
    rs_row_finish = 1'b1;
    tick();
    chk("g0_done",    32'(ch_row_done), 32'h1);
    chk("g0_release", 32'(ch_grant), 32'h0);
    rs_row_finish = 1'b0;
    tick();
    chk("g0_done_pulse", 32'(ch_row_done), 32'h0);

    // Channel 2 feeds a full row while channel 0 strobes junk.
    ch_req = 4'b0100;
    tick();
    chk("g2_grant", 32'(ch_grant), 32'h4);
    chk("g2_gid",   32'(grant_id), 32'h2);
    ch_req = 4'b0000;
    for (int b = 0; b < 240; b++) begin
      ch_en_in = 4'b0101;
      ch_din   = {8'h00, 8'(b), 8'h00, 8'hFF};
      tick();
      chk("feed", {23'h0, rs_en_in, rs_din}, {23'h0, 1'b1, 8'(b)});
    end
    ch_en_in = 4'b0100;
    ch_din   = {8'h00, 8'h77, 8'h00, 8'h00};
    tick();
    chk("byte241_blocked", 32'(rs_en_in), 32'h0);
    chk("drain_busy",      32'(busy), 32'h1);
    ch_en_in = 4'b0000;
    rs_row_finish = 1'b1;
    tick();
    chk("g2_done",    32'(ch_row_done), 32'h4);
    chk("g2_release", 32'(ch_grant), 32'h0);
    chk("g2_idle",    32'(busy), 32'h0);
    rs_row_finish = 1'b0;
    tick();
    chk("g2_done_pulse", 32'(ch_row_done), 32'h0);

    // Finish while idle is ignored.
    rs_row_finish = 1'b1;
    tick();
    chk("idle_finish_done", 32'(ch_row_done), 32'h0);
    chk("idle_finish_busy", 32'(busy), 32'h0);
    rs_row_finish = 1'b0;

    // Round-robin with all four requesting, one idle cycle between grants.
    do_reset();
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", 32'(ch_grant), 32'(4'b0001 << exp_order[k]));
      chk("rr_gid",   32'(grant_id), 32'(exp_order[k]));
      rs_row_finish = 1'b1;
      tick();
      chk("rr_idle_grant", 32'(ch_grant), 32'h0);
      chk("rr_idle_busy",  32'(busy), 32'h0);
      rs_row_finish = 1'b0;
    end
    ch_req = 4'b0000;
    tick();

    // Watchdog on the 16-cycle instance: channel 1 times out, channel 2 next.
    do_reset();
    ch_req = 4'b0110;
    tick();
    chk("to_grant1", 32'(t_ch_grant), 32'h2);
    for (int k = 0; k < 15; k++) tick();
    chk("to_early",      32'(t_ch_timeout), 32'h0);
    chk("to_early_busy", 32'(t_busy), 32'h1);
    tick();
    chk("to_pulse",   32'(t_ch_timeout), 32'h2);
    chk("to_release", 32'(t_ch_grant), 32'h0);
    chk("to_no_done", 32'(t_ch_row_done), 32'h0);
    tick();
    chk("to_next_grant", 32'(t_ch_grant), 32'h4);
    chk("to_pulse_end",  32'(t_ch_timeout), 32'h0);
    chk("main_still_1",  32'(ch_grant), 32'h2);
    ch_req = 4'b0000;
    rs_row_finish = 1'b1;
    tick();
    rs_row_finish = 1'b0;
    tick();

    // Finish and watchdog expiry in the same cycle: finish wins.
    ch_req = 4'b0001;
    tick();
    chk("tie_grant", 32'(t_ch_grant), 32'h1);
    ch_req = 4'b0000;
    for (int k = 0; k < 15; k++) tick();
    rs_row_finish = 1'b1;
    tick();
    chk("tie_done",    32'(t_ch_row_done), 32'h1);
    chk("tie_no_to",   32'(t_ch_timeout), 32'h0);
    rs_row_finish = 1'b0;
    tick();

    // Decoder output routed to channel 3 only; mode stays latched.
    do_reset();
    ch_req = 4'b1000;
    tick();
    chk("g3_grant", 32'(ch_grant), 32'h8);
    chk("g3_mode",  32'(rs_mode), 32'h3);
    ch_req     = 4'b0000;
    ch_rs_mode = 8'h00;
    rs_en_out  = 1'b1;
    rs_dout    = 8'hA5;
    tick();
    chk("route_en",   32'(ch_rs_en_out), 32'h8);
    chk("route_dout", 32'(ch_rs_dout), 32'hA5);
    chk("mode_hold",  32'(rs_mode), 32'h3);
    rs_en_out = 1'b0;
    tick();
    chk("route_pulse", 32'(ch_rs_en_out), 32'h0);
    rs_row_finish = 1'b1;
    tick();
    rs_row_finish = 1'b0;
    rs_en_out = 1'b1;
    rs_dout   = 8'h3C;
    tick();
    chk("idle_route", 32'(ch_rs_en_out), 32'h0);
    rs_en_out = 1'b0;

    // Reset in the middle of a row.
    ch_req = 4'b0001;
    tick();
    chk("r_grant", 32'(ch_grant), 32'h1);
    ch_req = 4'b0000;
    for (int b = 0; b < 100; b++) begin
      ch_en_in = 4'b0001;
      ch_din   = {24'h0, 8'(b + 1)};
      tick();
    end
    chk("r_pre_din", 32'(rs_din), 32'd100);
    reset_n = 1'b0;
    tick();
    chk("r_busy",  32'(busy), 32'h0);
    chk("r_grant0", 32'(ch_grant), 32'h0);
    chk("r_en_in", 32'(rs_en_in), 32'h0);
    chk("r_din",   32'(rs_din), 32'h0);
    chk("r_gid",   32'(grant_id), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("r_after_en_in", 32'(rs_en_in), 32'h0);
    ch_en_in = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
